// File: rtl/dmem_responder_if.sv
// Request/response bus between a load/store requester and the data-memory responder.
// Request channel: req_valid/req_ready handshake carrying we, byte address, store data and
// byte-lane strobes. Response channel: rsp_valid/rsp_ready handshake carrying load data and
// an error flag.
//   master : requester side (drives req_*, rsp_ready)
//   slave  : responder side (drives req_ready, rsp_*)
interface dmem_responder_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_wstrb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised RAM behind a valid/ready request/response port with
// a fixed number of wait cycles between accepting a request and presenting its response.
// One transaction in flight; stores honour byte strobes; misaligned or out-of-range
// accesses return rsp_err=1 with zero data and do not write.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset (memory contents are kept)
//   bus   : slave side of dmem_responder_if (request and response channels)
module dmem_responder #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned ADDR_W  = 32
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);
  localparam int unsigned IdxW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0]       mem_q [DEPTH];

  // Access path: with zero latency the access happens on the accept edge straight from the
  // bus; otherwise it uses the request captured at accept time.
  logic              acc_en;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic [3:0]        acc_wstrb;
  logic              acc_err;
  logic [IdxW-1:0]   acc_idx;
  logic              mem_wr;
  logic              idle_ready;

  always_comb begin
    acc_we    = (state_q == StIdle) ? bus.req_we    : we_q;
    acc_addr  = (state_q == StIdle) ? bus.req_addr  : addr_q;
    acc_wdata = (state_q == StIdle) ? bus.req_wdata : wdata_q;
    acc_wstrb = (state_q == StIdle) ? bus.req_wstrb : wstrb_q;
    acc_en    = ((state_q == StIdle) && bus.req_valid && (LATENCY == 0)) ||
                ((state_q == StWait) && (cnt_q == 4'd0));
    // Any address bit at or above the array span makes the access out of range.
    acc_err   = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (IdxW + 2)) != '0);
    acc_idx   = acc_addr[IdxW+1:2];
    mem_wr    = acc_en && acc_we && !acc_err;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    idle_ready = 1'b0;

    unique case (state_q)
      StIdle: begin
        idle_ready = 1'b1;
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          wstrb_d = bus.req_wstrb;
          if (LATENCY == 0) begin
            state_d = StResp;
          end else begin
            cnt_d   = 4'(LATENCY - 1);
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Response payload is latched on the access edge and held through StResp.
    if (acc_en) begin
      err_d   = acc_err;
      rdata_d = (acc_we || acc_err) ? 32'd0 : mem_q[acc_idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wstrb[i]) begin
          mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

  // Ready is forced low while reset is held even though the state reads StIdle.
  assign bus.req_ready = idle_ready && reset;
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (latency 2, 0 and 15) share clock and reset.
// A transaction-level model predicts ready/valid/data/err every cycle; directed sequences
// also pin literal results and latencies.
module tb_dmem_responder;
  localparam int NDUT = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rv   [NDUT];
  logic        rr   [NDUT];
  logic        we   [NDUT];
  logic [31:0] addr [NDUT];
  logic [31:0] wd   [NDUT];
  logic [3:0]  ws   [NDUT];
  logic        rsv  [NDUT];
  logic        rsr  [NDUT];
  logic [31:0] rd   [NDUT];
  logic        rerr [NDUT];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : gen_dut
    dmem_responder_if #(.ADDR_W(32)) bus ();
    assign bus.req_valid = rv[g];
    assign bus.req_we    = we[g];
    assign bus.req_addr  = addr[g];
    assign bus.req_wdata = wd[g];
    assign bus.req_wstrb = ws[g];
    assign bus.rsp_ready = rsr[g];
    assign rr[g]         = bus.req_ready;
    assign rsv[g]        = bus.rsp_valid;
    assign rd[g]         = bus.rsp_rdata;
    assign rerr[g]       = bus.rsp_err;
    dmem_responder #(
      .DEPTH  (64),
      .LATENCY((g == 0) ? 2 : ((g == 1) ? 0 : 15)),
      .ADDR_W (32)
    ) u_dut (
      .clk  (clk),
      .reset(reset_n),
      .bus  (bus.slave)
    );
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 0 : 15);
  endfunction

  function automatic logic bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'd256);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] v,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = v[8*i +: 8];
    return r;
  endfunction

  // ---------------- model: one outstanding transaction per instance ----------------
  logic        mbusy  [NDUT];
  logic        mresp  [NDUT];
  int          mage   [NDUT];
  logic        m_we   [NDUT];
  logic [31:0] m_addr [NDUT];
  logic [31:0] m_wd   [NDUT];
  logic [3:0]  m_ws   [NDUT];
  logic [31:0] m_rdata[NDUT];
  logic        m_err  [NDUT];
  logic [31:0] mmem   [NDUT][64];

  task automatic model_access(input int d, input logic w, input logic [31:0] a,
                              input logic [31:0] v, input logic [3:0] s);
    mresp[d]   <= 1'b1;
    m_err[d]   <= bad_addr(a);
    m_rdata[d] <= (w || bad_addr(a)) ? 32'd0 : mmem[d][a[7:2]];
    if (w && !bad_addr(a)) mmem[d][a[7:2]] <= merge(mmem[d][a[7:2]], v, s);
  endtask

  always @(posedge clk or negedge reset_n) begin
    for (int d = 0; d < NDUT; d++) begin
      if (!reset_n) begin
        mbusy[d] <= 1'b0;
        mresp[d] <= 1'b0;
        mage[d]  <= 0;
      end else if (!mbusy[d]) begin
        if (rv[d]) begin
          mbusy[d]  <= 1'b1;
          m_we[d]   <= we[d];
          m_addr[d] <= addr[d];
          m_wd[d]   <= wd[d];
          m_ws[d]   <= ws[d];
          mage[d]   <= 0;
          if (lat_of(d) == 0) model_access(d, we[d], addr[d], wd[d], ws[d]);
        end
      end else if (!mresp[d]) begin
        // mage counts edges since accept; the access falls on edge accept+latency.
        if (mage[d] + 1 == lat_of(d)) model_access(d, m_we[d], m_addr[d], m_wd[d], m_ws[d]);
        else mage[d] <= mage[d] + 1;
      end else if (rsr[d]) begin
        mbusy[d] <= 1'b0;
        mresp[d] <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got 0x%08h, expected 0x%08h at %0t", name, d, act, exp, $time);
    end
  endtask

  task automatic fail_bound(input string name, input int d);
    checks++;
    errors++;
    $display("FAIL %s dut%0d: wait bound expired at %0t", name, d, $time);
  endtask

  always @(posedge clk) begin
    #2;
    for (int d = 0; d < NDUT; d++) begin
      chk("req_ready", d, 32'(rr[d]), 32'(reset_n && !mbusy[d]));
      chk("rsp_valid", d, 32'(rsv[d]), 32'(mresp[d]));
      if (mresp[d]) begin
        chk("rsp_rdata", d, rd[d], m_rdata[d]);
        chk("rsp_err", d, 32'(rerr[d]), 32'(m_err[d]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input int d, input logic w, input logic [31:0] a, input logic [31:0] v,
                       input logic [3:0] s, output time t_acc);
    int k;
    @(negedge clk);
    rv[d] = 1'b1; we[d] = w; addr[d] = a; wd[d] = v; ws[d] = s;
    k = 0;
    while (!rr[d] && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!rr[d]) begin
      fail_bound("accept_timeout", d);
      rv[d] = 1'b0;
      t_acc = 0;
      return;
    end
    @(posedge clk);
    t_acc = $time;
    @(negedge clk);
    rv[d] = 1'b0;
  endtask

  // Starts on the falling edge after the accept edge; n = cycles until rsp_valid seen.
  task automatic collect(input int d, input int hold, output logic [31:0] rdata,
                         output logic err, output int n);
    n = 0;
    while (!rsv[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    rdata = rd[d];
    err   = rerr[d];
    if (!rsv[d]) begin
      fail_bound("rsp_timeout", d);
      return;
    end
    if (hold > 0) begin
      rsr[d] = 1'b0;
      repeat (hold) @(negedge clk);
      rsr[d] = 1'b1;
    end
    rdata = rd[d];
    err   = rerr[d];
    @(posedge clk);
  endtask

  task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] v,
                     input logic [3:0] s, output logic [31:0] rdata, output logic err,
                     output int n, output time t_acc);
    issue(d, w, a, v, s, t_acc);
    collect(d, 0, rdata, err, n);
  endtask

  initial begin
    logic [31:0] r;
    logic        e;
    int          n;
    time         t, tp;

    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic        e;
    int          n;
    time         t, tp;
    logic [31:0] a;

    reset_n = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      rv[d] = 1'b0; we[d] = 1'b0; addr[d] = 32'd0; wd[d] = 32'd0; ws[d] = 4'd0; rsr[d] = 1'b1;
    end
    #3;
    for (int d = 0; d < NDUT; d++) begin
      chk("reset_req_ready", d, 32'(rr[d]), 32'd0);
      chk("reset_rsp_valid", d, 32'(rsv[d]), 32'd0);
      chk("reset_rsp_rdata", d, rd[d], 32'd0);
      chk("reset_rsp_err", d, 32'(rerr[d]), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Full-word store then load, latency 2.
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, r, e, n, t);
    chk("t1_store_latency", 0, 32'(n), 32'd2);
    chk("t1_store_err", 0, 32'(e), 32'd0);
    chk("t1_store_rdata", 0, r, 32'd0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, r, e, n, t);
    chk("t1_load_rdata", 0, r, 32'hDEADBEEF);

    // Byte-lane strobes.
    txn(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, r, e, n, t);
    txn(0, 1'b0, 32'h10, 32'h0, 4'hF, r, e, n, t);
    chk("t2_lane0_rdata", 0, r, 32'hDEADBEAA);
    txn(0, 1'b1, 32'h10, 32'h12340000, 4'b1100, r, e, n, t);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, r, e, n, t);
    chk("t2_upper_rdata", 0, r, 32'h1234BEAA);

    // Error responses and a zero-strobe store leave memory untouched.
    txn(0, 1'b0, 32'h12, 32'h0, 4'h0, r, e, n, t);
    chk("t3_misaligned_err", 0, 32'(e), 32'd1);
    chk("t3_misaligned_rdata", 0, r, 32'd0);
    txn(0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, r, e, n, t);
    chk("t3_range_err", 0, 32'(e), 32'd1);
    txn(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, r, e, n, t);
    chk("t3_nostrobe_err", 0, 32'(e), 32'd0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, r, e, n, t);
    chk("t3_after_err_rdata", 0, r, 32'h1234BEAA);

    // Back-pressure: response held 5 cycles, next request waits until back in idle.
    issue(0, 1'b1, 32'h14, 32'hCAFEF00D, 4'hF, tp);
    rv[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h14; ws[0] = 4'h0;
    collect(0, 5, r, e, n);
    chk("t4_held_rdata", 0, r, 32'd0);
    issue(0, 1'b0, 32'h14, 32'h0, 4'h0, t);
    chk("t4_accept_spacing", 0, 32'((t - tp) / 10), 32'd9);
    collect(0, 0, r, e, n);
    chk("t4_load_rdata", 0, r, 32'hCAFEF00D);

    // Reset in the wait phase drops the pending store.
    issue(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'hF, t);
    reset_n = 1'b0;
    #1;
    chk("t5_reset_rsp_valid", 0, 32'(rsv[0]), 32'd0);
    chk("t5_reset_req_ready", 0, 32'(rr[0]), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("t5_release_req_ready", 0, 32'(rr[0]), 32'd1);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, r, e, n, t);
    chk("t5_load_rdata", 0, r, 32'h1234BEAA);

    // Zero-latency instance: back-to-back loads, one response every 2 cycles.
    txn(1, 1'b1, 32'h0, 32'h11111111, 4'hF, r, e, n, t);
    chk("t6_l0_store_latency", 1, 32'(n), 32'd0);
    txn(1, 1'b1, 32'h4, 32'h22222222, 4'hF, r, e, n, t);
    tp = 0;
    for (int i = 0; i < 4; i++) begin
      a = (i % 2 == 0) ? 32'h0 : 32'h4;
      txn(1, 1'b0, a, 32'h0, 4'h0, r, e, n, t);
      chk("t6_l0_rdata", 1, r, (i % 2 == 0) ? 32'h11111111 : 32'h22222222);
      if (i > 0) chk("t6_l0_spacing", 1, 32'((t - tp) / 10), 32'd2);
      tp = t;
    end

    // Latency-15 instance.
    txn(2, 1'b1, 32'h20, 32'h5A5A5A5A, 4'hF, r, e, n, t);
    chk("t6_l15_store_latency", 2, 32'(n), 32'd15);
    txn(2, 1'b0, 32'h20, 32'h0, 4'h0, r, e, n, t);
    chk("t6_l15_load_latency", 2, 32'(n), 32'd15);
    chk("t6_l15_rdata", 2, r, 32'h5A5A5A5A);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
